// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// ALU operation codes (ALU control decoder encoding), multiply/divide FSM
// state encodings, iteration count, datapath mode and op-class helpers.
package mul_div_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MD_ITER = 32;

  // ALU operation codes (5-bit); M-extension codes occupy 0x10..0x17.
  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_AND    = 5'h02;
  localparam logic [4:0] ALU_OR     = 5'h03;
  localparam logic [4:0] ALU_XOR    = 5'h04;
  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHSU = 5'h12;
  localparam logic [4:0] ALU_MULHU  = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_SIGN = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  typedef enum logic {
    MD_MODE_MUL = 1'b0,
    MD_MODE_DIV = 1'b1
  } md_mode_e;

  function automatic logic is_m_op(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Shared one-bit-per-cycle datapath for the multiply/divide unit.
// A single 64-bit register holds either the product accumulator
// {high, low/multiplier} or the division state {remainder, quotient/dividend};
// r_opnd holds the multiplicand or divisor magnitude.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   i_load        - load i_load_acc / i_load_opnd
//   i_iter_en     - perform one shift-add or restoring shift-subtract step
//   i_mode        - selects multiply or divide step
//   i_load_acc    - initial accumulator contents
//   i_load_opnd   - multiplicand / divisor magnitude
//   o_acc         - accumulator contents
module md_datapath
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_iter_en,
  input  md_mode_e    i_mode,
  input  logic [63:0] i_load_acc,
  input  logic [31:0] i_load_opnd,
  output logic [63:0] o_acc
);

  logic [63:0] r_acc;
  logic [31:0] r_opnd;

  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_acc_next;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole 65-bit value right.
    w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    // Divide: shift next dividend bit into the remainder, trial-subtract.
    w_div_shift = r_acc[63:31];
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // The difference is below the divisor, so 32 bits are enough.
    w_div_sub   = w_div_shift[31:0] - r_opnd;
    if (i_mode == MD_MODE_MUL) begin
      w_acc_next = {w_mul_sum, r_acc[31:1]};
    end else if (w_div_ge) begin
      w_acc_next = {w_div_sub, r_acc[30:0], 1'b1};
    end else begin
      w_acc_next = {w_div_shift[31:0], r_acc[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_acc  <= i_load_acc;
      r_opnd <= i_load_opnd;
    end else if (i_iter_en) begin
      r_acc  <= w_acc_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide execution unit with start/busy/done
// handshake. Operates on operand magnitudes for 32 cycles, then applies
// sign correction and registers the result.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   start  - request a new operation (sampled in IDLE or DONE)
//   flush  - abort any operation in flight; wins over start
//   op     - 5-bit ALU operation code (M-extension codes accepted)
//   a, b   - rs1 / rs2 operands
//   busy   - high while computing (CALC, SIGN)
//   done   - one-cycle pulse, result valid
//   result - registered result, held until the next completion
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   r_state, w_next;
  logic [5:0]  r_cnt;
  logic [4:0]  r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_result;

  logic        w_load;
  logic        w_iter;
  logic        w_a_signed, w_b_signed;
  logic        w_sa, w_sb;
  logic [31:0] w_mag_a, w_mag_b;
  logic        w_div0, w_ovf, w_fast;
  logic [63:0] w_load_acc;
  logic [63:0] w_acc;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;
  logic [31:0] w_sign_result;
  md_mode_e    w_mode;

  // Operand decode for the incoming request.
  always_comb begin
    w_a_signed = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    w_b_signed = op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    w_sa       = w_a_signed & a[31];
    w_sb       = w_b_signed & b[31];
    w_mag_a    = w_sa ? (32'd0 - a) : a;
    w_mag_b    = w_sb ? (32'd0 - b) : b;
    w_div0     = is_div_op(op) && (b == '0);
    w_ovf      = (op inside {ALU_DIV, ALU_REM}) &&
                 (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    w_fast     = w_div0 | w_ovf;
    // Fast paths preload the final {remainder, quotient} and skip CALC;
    // their sign flags are cleared so SIGN passes the values through.
    if (w_div0) begin
      w_load_acc = {a, 32'hFFFF_FFFF};
    end else if (w_ovf) begin
      w_load_acc = {32'd0, 32'h8000_0000};
    end else begin
      w_load_acc = {32'd0, w_mag_a};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_iter = 1'b0;
    if (flush) begin
      w_next = MD_IDLE;
    end else begin
      case (r_state)
        MD_IDLE, MD_DONE: begin
          w_next = MD_IDLE;
          if (start && is_m_op(op)) begin
            w_load = 1'b1;
            w_next = w_fast ? MD_SIGN : MD_CALC;
          end
        end
        MD_CALC: begin
          w_iter = 1'b1;
          if (r_cnt == 6'(MD_ITER - 1)) begin
            w_next = MD_SIGN;
          end
        end
        MD_SIGN: w_next = MD_DONE;
        default: w_next = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_op    <= ALU_ADD;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_load) begin
      r_cnt   <= '0;
      r_op    <= op;
      r_neg_q <= w_fast ? 1'b0 : (w_sa ^ w_sb);
      r_neg_r <= w_fast ? 1'b0 : w_sa;
    end else if (w_iter) begin
      r_cnt   <= r_cnt + 6'd1;
    end
  end

  assign w_mode = is_div_op(r_op) ? MD_MODE_DIV : MD_MODE_MUL;

  md_datapath u_dp (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_iter_en   (w_iter),
    .i_mode      (w_mode),
    .i_load_acc  (w_load_acc),
    .i_load_opnd (w_mag_b),
    .o_acc       (w_acc)
  );

  // Sign correction and output selection.
  always_comb begin
    w_prod = r_neg_q ? (64'd0 - w_acc) : w_acc;
    w_quo  = r_neg_q ? (32'd0 - w_acc[31:0]) : w_acc[31:0];
    w_rem  = r_neg_r ? (32'd0 - w_acc[63:32]) : w_acc[63:32];
    case (r_op)
      ALU_MUL:                          w_sign_result = w_prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  w_sign_result = w_prod[63:32];
      ALU_DIV, ALU_DIVU:                w_sign_result = w_quo;
      ALU_REM, ALU_REMU:                w_sign_result = w_rem;
      default:                          w_sign_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
    end else if (r_state == MD_SIGN && !flush) begin
      r_result <= w_sign_result;
    end
  end

  assign busy   = (r_state == MD_CALC) || (r_state == MD_SIGN);
  assign done   = (r_state == MD_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  op    = '0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  mul_div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned at;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests  = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int          done_cnt = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endtask

  // Reference model straight from the RV32M arithmetic definitions.
  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    int          sx, sy;
    logic [63:0] p;
    logic        ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      ALU_MUL:    begin p = longint'(sx) * longint'(sy); return p[31:0]; end
      ALU_MULH:   begin p = longint'(sx) * longint'(sy); return p[63:32]; end
      ALU_MULHSU: begin p = longint'(sx) * longint'({32'd0, y}); return p[63:32]; end
      ALU_MULHU:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      ALU_DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sx / sy);
      ALU_REM:    return (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
      ALU_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      ALU_REMU:   return (y == 0) ? x : x % y;
      default:    return '0;
    endcase
  endfunction

  function automatic int unsigned latency(input logic [4:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    logic dv;
    dv = (o == ALU_DIV) || (o == ALU_DIVU) || (o == ALU_REM) || (o == ALU_REMU);
    if (dv && y == 0) return 2;
    if ((o == ALU_DIV || o == ALU_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Caller is positioned at a negedge; start is sampled by the next posedge.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit chk, input string nm);
    exp_t e;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (chk) begin
      e.res  = ref_model(o, x, y);
      e.at   = cyc + latency(o, x, y);
      e.name = nm;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("ready_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      done_cnt++;
      check("busy_done_excl", 32'(busy), 32'd0);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h, expected no done", result);
      end else begin
        e = sb_q.pop_front();
        check(e.name, result, e.res);
        check({e.name, "_cycle"}, cyc, e.at);
        last_res = e.res;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    string       nm;
  } vec_t;

  vec_t        dir[12];
  logic [4:0]  mops[8];
  logic [31:0] prev;
  int          d0;

  initial begin
    dir[0]  = '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, "mul_7_m3"};
    dir[1]  = '{ALU_MULH,   32'd7,          32'hFFFF_FFFD, "mulh_7_m3"};
    dir[2]  = '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu_max"};
    dir[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,         "mulhsu_m1_2"};
    dir[4]  = '{ALU_DIV,    32'hFFFF_FFF9,  32'd2,         "div_m7_2"};
    dir[5]  = '{ALU_REM,    32'hFFFF_FFF9,  32'd2,         "rem_m7_2"};
    dir[6]  = '{ALU_DIVU,   32'd100,        32'd7,         "divu_100_7"};
    dir[7]  = '{ALU_REMU,   32'd100,        32'd7,         "remu_100_7"};
    dir[8]  = '{ALU_DIVU,   32'd5,          32'd0,         "divu_by0"};
    dir[9]  = '{ALU_REM,    32'd5,          32'd0,         "rem_by0"};
    dir[10] = '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf"};
    dir[11] = '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf"};
    mops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    // Reset state.
    #1;
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", result,    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back-to-back as soon as the unit is free.
    foreach (dir[i]) begin
      wait_ready();
      issue(dir[i].o, dir[i].x, dir[i].y, 1'b1, dir[i].nm);
    end
    wait_drain();

    // Start while busy is ignored.
    issue(ALU_DIVU, 32'd100, 32'd7, 1'b1, "busy_ignore");
    repeat (9) @(negedge clk);
    op = ALU_MUL; a = 32'd1234; b = 32'd5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Non-M op: no busy, no done.
    d0 = done_cnt;
    issue(ALU_ADD, 32'd1, 32'd2, 1'b0, "");
    check("add_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("add_no_done", 32'(done_cnt), 32'(d0));

    // Flush at T+20.
    prev = last_res;
    d0   = done_cnt;
    issue(ALU_MUL, 32'd9, 32'd9, 1'b0, "");
    repeat (19) @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush_idle",   32'(busy), 32'd0);
    check("flush_result", result,    prev);
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(done_cnt), 32'(d0));

    // Asynchronous reset at T+15.
    issue(ALU_MUL, 32'd11, 32'd13, 1'b0, "");
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy",   32'(busy), 32'd0);
    check("arst_done",   32'(done), 32'd0);
    check("arst_result", result,    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    @(negedge clk);
    issue(ALU_MUL, 32'd3, 32'd4, 1'b1, "mul_after_reset");
    wait_drain();

    // Randomized operations with injected corner operands.
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  ro;
      logic [31:0] rx, ry;
      int unsigned sel;
      ro  = mops[$urandom_range(0, 7)];
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = '0;
      else if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (sel == 2) begin rx = $urandom_range(0, 50); ry = $urandom_range(1, 9); end
      else if (sel == 3) ry = 32'hFFFF_FFFF - $urandom_range(0, 3);
      wait_ready();
      issue(ro, rx, ry, 1'b1, "random");
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
